bram_word_loader: RTL

//  Upstream write-side feeder for the simple-dual-port instruction/data BRAM.

---
 rtl/riscv_pkg.sv | 6 +
 rtl/bram_word_loader_byte_packer.sv | 33 +++
 rtl/bram_word_loader.sv | 113 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared loader state type and word-packing constants.
package riscv_pkg;
    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} loader_state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);
endpackage

// File: rtl/bram_word_loader_byte_packer.sv
// byte_packer: gathers little-endian bytes into one word; a flush zeroes the lanes
// that were not filled before the word is closed.
module byte_packer
    import riscv_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        accept,
    input  logic                        flush,
    input  logic [7:0]                  data,
    output logic [8*BYTES_PER_WORD-1:0] word,
    output logic [IDX_W-1:0]            byte_idx,
    output logic                        word_full
);
    localparam int FW = IDX_W + 1;
    // bytes held once this cycle's byte (if any) is counted
    logic [FW-1:0] fill;
    assign fill      = {1'b0, byte_idx} + FW'(accept);
    assign word_full = fill == FW'(BYTES_PER_WORD);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            word     <= '0;
            byte_idx <= '0;
        end else begin
            byte_idx <= (clear || flush) ? '0 : fill[IDX_W-1:0];
            for (int k = 0; k < BYTES_PER_WORD; k++)
                if (accept && byte_idx == IDX_W'(k))
                    word[8*k+:8] <= data;
                else if (flush && FW'(k) >= fill)
                    word[8*k+:8] <= 8'h00;
        end
endmodule

// File: rtl/bram_word_loader.sv
// bram_word_loader: packs a byte stream into 32-bit words written to consecutive BRAM
// addresses. Define LOADER_CHECKSUM_EN to add a running sum of written words.
module bram_word_loader
    import riscv_pkg::*;
#(
    parameter int SIZE       = 512,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  flush,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  ena,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] dia,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]           checksum
`endif
);
    localparam int CW = ADDR_WIDTH + 1;
    loader_state_t    state, next_state;
    logic             accept, go, last, flush_pending, word_full;
    logic [IDX_W-1:0] byte_idx;
    logic             s_ready_d, ena_d, busy_d, done_d;

    if (DATA_WIDTH != 8 * BYTES_PER_WORD) begin : g_width_check
        $error("bram_word_loader: DATA_WIDTH must be 32");
    end
    if (2 ** ADDR_WIDTH < SIZE) begin : g_depth_check
        $error("bram_word_loader: ADDR_WIDTH too small for SIZE");
    end

    assign accept = s_valid && s_ready;
    assign go     = start && (state == IDLE || state == DONE);
    assign last   = addra == ADDR_WIDTH'(SIZE - 1);

    byte_packer u_packer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (go),
        .accept   (accept),
        .flush    (state == FILL && flush),
        .data     (s_data),
        .word     (dia),
        .byte_idx (byte_idx),
        .word_full(word_full)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: next_state = start ? FILL : state;
            FILL:       next_state = (word_full || (flush && (accept || byte_idx != '0))) ? WRITE
                                   : flush ? DONE : FILL;
            WRITE:      next_state = (last || flush_pending || flush) ? DONE : FILL;
        endcase
    end

    // outputs are registered from the upcoming state so they line up with it
    always_comb begin
        s_ready_d = next_state == FILL;
        ena_d     = next_state == WRITE;
        busy_d    = next_state == FILL || next_state == WRITE;
        done_d    = next_state == DONE;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            s_ready       <= 1'b0;
            ena           <= 1'b0;
            wea           <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            addra         <= '0;
            word_count    <= '0;
            flush_pending <= 1'b0;
        end else begin
            s_ready       <= s_ready_d;
            ena           <= ena_d;
            wea           <= ena_d;
            busy          <= busy_d;
            done          <= done_d;
            flush_pending <= state == FILL && flush;
            if (go) begin
                addra      <= base_addr;
                word_count <= '0;
            end else if (state == WRITE) begin
                word_count <= word_count + CW'(1);
                if (next_state == FILL) addra <= addra + ADDR_WIDTH'(1);
            end
        end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)            checksum <= '0;
        else if (go)             checksum <= '0;
        else if (state == WRITE) checksum <= checksum + dia;
`endif
endmodule
